// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the uart line echo controller.
package uart_ctrl_pkg;

    localparam int unsigned GREET_LEN = 12;
    localparam logic [7:0]  CR_BYTE   = 8'h0D;
    localparam logic [7:0]  LF_BYTE   = 8'h0A;

    typedef enum logic [2:0] {
        GREET,
        COLLECT,
        FLUSH,
        CR,
        LF
    } ctrl_state_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO
    } send_state_e;

    // "Hello World!" indexed by position.
    function automatic logic [7:0] greet_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h48;
            4'd1:    return 8'h65;
            4'd2:    return 8'h6C;
            4'd3:    return 8'h6C;
            4'd4:    return 8'h6F;
            4'd5:    return 8'h20;
            4'd6:    return 8'h57;
            4'd7:    return 8'h6F;
            4'd8:    return 8'h72;
            4'd9:    return 8'h6C;
            4'd10:   return 8'h64;
            4'd11:   return 8'h21;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte transmit handshake with the uart core, with a watchdog on the
// transmitter failing to report busy.
module uart_byte_sender
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned START_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       done,
    output logic       fault
);

    localparam int unsigned CNT_W = $clog2(START_WAIT + 1);

    send_state_e      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             transmit_d;
    logic [7:0]       tx_byte_d;
    logic             done_d;
    logic             fault_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            transmit <= 1'b0;
            tx_byte  <= 8'h00;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            transmit <= transmit_d;
            tx_byte  <= tx_byte_d;
            done     <= done_d;
            fault    <= fault_d;
        end
    end

    // tx_byte only changes on launch, so it stays stable for the whole byte.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte;
        done_d     = 1'b0;
        fault_d    = fault;
        case (state)
            IDLE: begin
                if (start && !is_transmitting) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = data;
                    cnt_d      = '0;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (is_transmitting) begin
                    state_d = WAIT_LO;
                end else if (cnt == CNT_W'(START_WAIT - 1)) begin
                    fault_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!is_transmitting) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_line_echo_ctrl.sv
// Greets after reset, then buffers received lines and echoes them with CR LF.
module uart_line_echo_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned LINE_MAX   = 8,
    parameter logic [7:0]  TERM_CHAR  = 8'h0D,
    parameter int unsigned START_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       overflow,
    output logic       tx_fault,
    output logic [7:0] rx_err_cnt
);

    localparam int unsigned IDX_W = $clog2(LINE_MAX);
    localparam int unsigned PTR_W = IDX_W + 1;

    ctrl_state_e      state, state_d;
    logic [3:0]       greet_idx, greet_idx_d;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_d;
    logic [7:0]       line_buf [LINE_MAX];
    logic             buf_we;
    logic             start;
    logic [7:0]       send_data;
    logic             done;

    uart_byte_sender #(
        .START_WAIT(START_WAIT)
    ) u_sender (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .data           (send_data),
        .is_transmitting(is_transmitting),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .done           (done),
        .fault          (tx_fault)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= GREET;
            greet_idx  <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            busy       <= 1'b1;
            overflow   <= 1'b0;
            rx_err_cnt <= 8'd0;
        end else begin
            state     <= state_d;
            greet_idx <= greet_idx_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            busy      <= (state_d != COLLECT);
            if (received && recv_error && rx_err_cnt != 8'hFF)
                rx_err_cnt <= rx_err_cnt + 8'd1;
            if (received && !recv_error && state != COLLECT)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            line_buf[wr_ptr[IDX_W-1:0]] <= rx_byte;
    end

    // start is held off during done so the sender never relaunches stale data.
    always_comb begin
        state_d     = state;
        greet_idx_d = greet_idx;
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        buf_we      = 1'b0;
        start       = 1'b0;
        send_data   = 8'h00;
        case (state)
            GREET: begin
                start     = !done;
                send_data = greet_byte(greet_idx);
                if (done) begin
                    greet_idx_d = greet_idx + 4'd1;
                    if (greet_idx == 4'(GREET_LEN - 1))
                        state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (received && !recv_error) begin
                    if (rx_byte == TERM_CHAR) begin
                        state_d = (wr_ptr == '0) ? CR : FLUSH;
                    end else begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr + 1'b1;
                        if (wr_ptr_d == PTR_W'(LINE_MAX))
                            state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                start     = !done;
                send_data = line_buf[rd_ptr[IDX_W-1:0]];
                if (done) begin
                    rd_ptr_d = rd_ptr + 1'b1;
                    if (rd_ptr_d == wr_ptr)
                        state_d = CR;
                end
            end
            CR: begin
                start     = !done;
                send_data = CR_BYTE;
                if (done)
                    state_d = LF;
            end
            LF: begin
                start     = !done;
                send_data = LF_BYTE;
                if (done) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = GREET;
        endcase
    end

endmodule

// File: doc/uart_line_echo_ctrl.md
Name: uart_line_echo_ctrl

Overview:
Controller that sequences the shared uart core's transmit and receive sides. After reset it sends a fixed greeting string. It then collects received bytes into a line buffer and echoes the whole line back, followed by CR LF, when a terminator arrives or the buffer fills. It sits between the board top level and the uart instance, driving transmit/tx_byte and consuming received/rx_byte/recv_error/is_transmitting.

Parameters:
LINE_MAX, 8, line buffer depth in bytes (power of 2, 2..64)
TERM_CHAR, 8'h0D, byte that ends a line (not stored, not echoed)
START_WAIT, 15, max cycles to wait for is_transmitting to rise after a transmit pulse

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
received  in  1  one-cycle strobe from uart: rx_byte valid
rx_byte  in  8  received byte
recv_error  in  1  one-cycle strobe: framing error on current byte
is_transmitting  in  1  uart transmitter busy
transmit  out  1  one-cycle pulse: uart to send tx_byte
tx_byte  out  8  byte to send; held stable from the pulse until the byte completes
busy  out  1  high in any state except COLLECT
overflow  out  1  sticky: a byte was dropped (received while not in COLLECT)
tx_fault  out  1  sticky: START_WAIT expired
rx_err_cnt  out  8  framing-error count, saturates at 255

Behaviour:
- Reset (async assert, sync release): state=GREET, greet_idx=0, wr_ptr=0, rd_ptr=0. Outputs: transmit=0, tx_byte=0, busy=1, overflow=0, tx_fault=0, rx_err_cnt=0.
- Greeting: 12 bytes, "Hello World!".
- Top FSM states: GREET, COLLECT, FLUSH, CR, LF.
  - GREET: send greeting[greet_idx] through the byte sequencer. On done, increment greet_idx. After index 11 completes, go to COLLECT.
  - COLLECT: on received & !recv_error:
    - rx_byte==TERM_CHAR: go to FLUSH (or CR if wr_ptr==0).
    - Otherwise store at buf[wr_ptr] and increment wr_ptr. If wr_ptr reaches LINE_MAX, go to FLUSH. The terminator is not required in this case.
  - FLUSH: send buf[rd_ptr] and increment rd_ptr on done. When rd_ptr==wr_ptr, go to CR.
  - CR: send 8'h0D. Then go to LF.
  - LF: send 8'h0A. Then clear wr_ptr and rd_ptr and go to COLLECT.
- Receive side, every state:
  - received & recv_error: byte discarded, rx_err_cnt += 1 (saturating). Error wins over received in the same cycle.
  - received outside COLLECT: byte dropped, overflow set.
- Byte sequencer handshake, per byte:
  - IDLE: on start with !is_transmitting, drive transmit=1 for exactly one cycle and latch tx_byte. If is_transmitting is high, stay in IDLE until it is low.
  - WAIT_HI: wait for is_transmitting=1. After START_WAIT cycles without it, set tx_fault and report done.
  - WAIT_LO: wait for is_transmitting=0, then assert done for one cycle.
  - Latency: at most one transmit pulse per byte. The next pulse comes no earlier than 1 cycle after done.
- First transmit pulse occurs in the first clk cycle after rst deasserts, with tx_byte=8'h48.
- Pointers are $clog2(LINE_MAX)+1 bits wide, so the full condition is exact with no wrap ambiguity.
- Reset mid-transmission: all state cleared immediately and the greeting restarts. A uart byte already in flight is not aborted by this block.

Decomposition:
- Package uart_ctrl_pkg holds:
  - state enum constants (GREET, COLLECT, FLUSH, CR, LF)
  - CR/LF constants
  - greeting length 12 and the greeting byte constants
- Sub-module uart_byte_sender: the IDLE/WAIT_HI/WAIT_LO handshake and START_WAIT counter. Ports: clk, rst, start, data[8], is_transmitting, transmit, tx_byte, done, fault.

Test Plan:
- Reset release with a uart model whose is_transmitting is high for 10 cycles after each pulse -> 12 pulses, tx_byte sequence 48 65 6C 6C 6F 20 57 6F 72 6C 64 21; busy falls after the last done.
- In COLLECT, send "abc" then 0D -> pulses carry 61 62 63 0D 0A; pointers return to 0; busy=0 afterwards.
- In COLLECT, send 8 bytes 30..37 with no terminator -> auto-flush 30..37 then 0D 0A; the 9th byte, sent during flush, sets overflow=1.
- In COLLECT, send 0D alone -> only 0D 0A transmitted.
- Assert received with recv_error in the same cycle, 3 times -> rx_err_cnt=3, nothing stored. Then drive 256 more errors -> rx_err_cnt=255.
- Hold is_transmitting low forever after a pulse -> tx_fault=1 after 15 cycles and the sequence advances to the next greeting byte. Separately, asserting rst during FLUSH -> next pulse after release is 8'h48.
